mux_arbiter: RTL and testbench
==============================

Name: mux_arbiter

Overview:
- Two-requester round-robin scheduler for the shared N-bit 2:1 select datapath.
- Grants the output channel to one source for a whole packet, delimited by last.
- Owns the mux select and the per-source ready backpressure.
- Bounds packet length with a beat limit so neither source can starve the other.

Parameters:
- N, 8, data width of each source and of the output.
- MAX_BEATS, 16, maximum beats per grant before forced release; must be >= 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- valid0  input  1  source 0 has a beat.
- data0  input  N  source 0 beat data.
- last0  input  1  source 0 beat ends its packet.
- ready0  output  1  source 0 beat accepted when valid0 and ready0 are both high.
- valid1  input  1  source 1 has a beat.
- data1  input  N  source 1 beat data.
- last1  input  1  source 1 beat ends its packet.
- ready1  output  1  source 1 beat accepted when valid1 and ready1 are both high.
- out_valid  output  1  output beat valid.
- out_data  output  N  granted source data.
- out_last  output  1  granted source last.
- out_ready  input  1  sink accepts a beat.
- sel  output  1  current owner; 0 = source 0, 1 = source 1.
- busy  output  1  a grant is held.
- trunc  output  1  one-cycle pulse when a packet was cut at MAX_BEATS.

Behaviour:
- One clock domain; reset is asynchronous and active-low.
- Reset (async assert, any time including mid-packet):
  - State goes to IDLE and the priority pointer is set so source 0 wins the first tie.
  - sel=0, busy=0, trunc=0, out_valid=0, ready0=0, ready1=0, beat count=0.
  - Deassertion is sampled on clk; no transfer occurs in the first cycle after release.
- FSM states: IDLE, OWN0, OWN1. sel and busy are registered decodes of state: sel=1 iff OWN1; busy=1 iff OWN0 or OWN1.
- IDLE:
  - out_valid=0, ready0=0, ready1=0.
  - Only valid0 high -> OWN0. Only valid1 high -> OWN1.
  - Both high -> grant the source that was not the most recent owner.
  - Neither high -> stay in IDLE.
- Grant latency: 1 cycle. The earliest transfer is the cycle after valid is first sampled in IDLE.
- OWNx (combinational pass-through from source x):
  - out_valid=validx, out_data=datax, out_last=lastx.
  - readyx=out_ready; the non-owner ready is 0.
- Beat counting:
  - A transfer is out_valid and out_ready both high.
  - The counter increments on each transfer and clears to 0 on every grant.
  - Counter width is clog2(MAX_BEATS+1).
- Release of OWNx:
  - Release occurs on a transfer with lastx=1, or on the transfer that brings the count to MAX_BEATS.
  - On release, the last-owner pointer is set to x.
- Next state after release:
  - If the other source's valid is high in the release cycle, go directly to OWN(other), with no bubble.
  - Otherwise go to IDLE. The same source re-acquires only via IDLE, a one-cycle bubble that guarantees fairness.
- trunc:
  - Registered; high for exactly one cycle after a release caused by the count reaching MAX_BEATS with lastx=0.
  - If lastx=1 on the MAX_BEATS-th beat, trunc stays 0.
  - Remaining beats of a cut packet are arbitrated as a new packet.
- Owner valid drops mid-packet: stay in OWNx (the grant is held until last or the limit); out_valid follows validx.
- Non-owner valid never affects the output; its beats stall with ready=0.
- Stability: data, last and valid from a source are held until accepted; the block neither checks nor corrects violations.

Test Plan:
- Single packet: N=8, MAX_BEATS=4; valid0 with 3 beats 0x11,0x22,0x33 (last on 0x33), out_ready=1.
  - First transfer 1 cycle after valid0 rises.
  - out_data 0x11,0x22,0x33 on consecutive cycles; sel=0, busy=1.
  - Returns to IDLE; trunc=0.
- Tie and round-robin: valid0 and valid1 both rise in the same cycle from reset, 2-beat packets each (0xA0,0xA1 / 0xB0,0xB1).
  - Source 0 is served first, then source 1 with no idle cycle: sel 0,0,1,1.
  - The next tie goes to source 0.
- Backpressure: during OWN1, toggle out_ready 1,0,0,1.
  - ready1 mirrors out_ready exactly; ready0 stays 0.
  - Beats transfer only on cycles with out_ready=1; the count reaches 2.
- Truncation: MAX_BEATS=4, source 0 sends 6 beats with last on beat 6; valid1 idle.
  - Release after beat 4; trunc pulses 1 cycle.
  - Grant goes via IDLE (bubble); beats 5-6 are sent as a new grant; trunc=0 at their end.
- Reset mid-packet: assert rst_n=0 after beat 2 of 5 in OWN1.
  - Immediately sel=0, busy=0, out_valid=0, ready1=0.
  - After release with only valid0 high, OWN0 is granted 1 cycle later.
- Last on limit beat: MAX_BEATS=4, packet of exactly 4 beats with last on beat 4 -> release; trunc remains 0.

Source files
------------

// File: rtl/mux_arbiter.sv
// Two-source round-robin packet arbiter for a shared N-bit 2:1 select datapath.
// Holds a grant for a whole packet, bounded by MAX_BEATS beats per grant.
module mux_arbiter #(
  parameter int unsigned N         = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         valid0,
  input  logic [N-1:0] data0,
  input  logic         last0,
  output logic         ready0,
  input  logic         valid1,
  input  logic [N-1:0] data1,
  input  logic         last1,
  output logic         ready1,
  output logic         out_valid,
  output logic [N-1:0] out_data,
  output logic         out_last,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy,
  output logic         trunc
);

  localparam int unsigned CntW = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } state_e;

  state_e          state_q, state_d;
  logic            last_owner_q, last_owner_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic            trunc_q, trunc_d;
  logic            sel_q, busy_q;
  logic            xfer, hit, rel, other_valid;

  // Owner pass-through; the non-owner always sees ready low.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    ready0    = 1'b0;
    ready1    = 1'b0;
    unique case (state_q)
      StOwn0: begin
        out_valid = valid0;
        out_data  = data0;
        out_last  = last0;
        ready0    = out_ready;
      end
      StOwn1: begin
        out_valid = valid1;
        out_data  = data1;
        out_last  = last1;
        ready1    = out_ready;
      end
      default: ;
    endcase
  end

  assign xfer        = out_valid & out_ready;
  assign cnt_inc     = cnt_q + CntW'(1);
  assign hit         = (cnt_inc == CntW'(MAX_BEATS));
  assign rel         = xfer & (out_last | hit);
  assign other_valid = (state_q == StOwn0) ? valid1 : valid0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_owner_d = last_owner_q;
    trunc_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        // On a tie, last_owner_q=1 hands the grant to source 0.
        if (valid0 && (!valid1 || last_owner_q)) begin
          state_d = StOwn0;
        end else if (valid1) begin
          state_d = StOwn1;
        end
      end
      StOwn0, StOwn1: begin
        if (xfer) begin
          cnt_d = cnt_inc;
        end
        if (rel) begin
          cnt_d        = '0;
          last_owner_d = (state_q == StOwn1);
          trunc_d      = hit & ~out_last;
          if (other_valid) begin
            state_d = (state_q == StOwn0) ? StOwn1 : StOwn0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_owner_q <= 1'b1;
      cnt_q        <= '0;
      trunc_q      <= 1'b0;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      trunc_q      <= trunc_d;
      sel_q        <= (state_d == StOwn1);
      busy_q       <= (state_d != StIdle);
    end
  end

  assign sel   = sel_q;
  assign busy  = busy_q;
  assign trunc = trunc_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// Bench for mux_arbiter: directed scenarios plus random traffic checked every cycle
// against a packet-level reference model of the grant rules.
module tb_mux_arbiter;
  localparam int unsigned N  = 8;
  localparam int unsigned MB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         valid0 = 1'b0, last0 = 1'b0, valid1 = 1'b0, last1 = 1'b0;
  logic [N-1:0] data0 = '0, data1 = '0;
  logic         ready0, ready1, out_valid, out_last, sel, busy, trunc;
  logic [N-1:0] out_data;
  logic         out_ready = 1'b0;

  always #5 clk = ~clk;

  mux_arbiter #(.N(N), .MAX_BEATS(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid0(valid0), .data0(data0), .last0(last0), .ready0(ready0),
    .valid1(valid1), .data1(data1), .last1(last1), .ready1(ready1),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy), .trunc(trunc)
  );

  int checks = 0;
  int errors = 0;

  logic [N:0] q0[$];
  logic [N:0] q1[$];
  logic       pres0 = 1'b0, pres1 = 1'b0;
  bit         gaps = 1'b0;

  // Model: owner (-1 none), beats granted so far, most recent owner, pending trunc pulse.
  int   m_own = -1, m_cnt = 0, m_last = 1;
  logic m_trunc = 1'b0;
  int   n_own, n_cnt, n_last;
  logic n_trunc;
  bit   acc0, acc1;
  int   trunc_seen = 0, acc1_cnt = 0;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    valid0 = pres0;
    {last0, data0} = pres0 ? q0[0] : '0;
    valid1 = pres1;
    {last1, data1} = pres1 ? q1[0] : '0;
  endtask

  task automatic present_now();
    if (!pres0) pres0 = (q0.size() > 0);
    if (!pres1) pres1 = (q1.size() > 0);
    drive();
  endtask

  task automatic push(input int src, input int len, input logic [N-1:0] base);
    for (int k = 0; k < len; k++) begin
      if (src == 0) q0.push_back({k == len - 1, base + N'(k)});
      else          q1.push_back({k == len - 1, base + N'(k)});
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_cnt = 0; m_last = 1; m_trunc = 1'b0;
  endtask

  // Called at posedge+1 with inputs settled; returns at the next posedge+1.
  task automatic step();
    logic         e_ov, e_ol, e_r0, e_r1;
    logic [N-1:0] e_od;
    #4;
    e_ov = 1'b0; e_ol = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_od = '0;
    if (m_own == 0) begin
      e_ov = valid0; e_od = data0; e_ol = last0; e_r0 = out_ready;
    end else if (m_own == 1) begin
      e_ov = valid1; e_od = data1; e_ol = last1; e_r1 = out_ready;
    end
    chk("out_valid", out_valid, e_ov);
    if (e_ov) begin
      chk("out_data", out_data, e_od);
      chk("out_last", out_last, e_ol);
    end
    chk("ready0", ready0, e_r0);
    chk("ready1", ready1, e_r1);
    chk("sel", sel, m_own == 1);
    chk("busy", busy, m_own >= 0);
    chk("trunc", trunc, m_trunc);
    if (trunc === 1'b1) trunc_seen++;
    acc0 = valid0 && e_r0;
    acc1 = valid1 && e_r1;
    if (acc1) acc1_cnt++;

    n_own = m_own; n_cnt = m_cnt; n_last = m_last; n_trunc = 1'b0;
    if (m_own < 0) begin
      if (valid0 && valid1) n_own = (m_last == 1) ? 0 : 1;
      else if (valid0)      n_own = 0;
      else if (valid1)      n_own = 1;
      n_cnt = 0;
    end else if (e_ov && out_ready) begin
      n_cnt = m_cnt + 1;
      if (e_ol || n_cnt == MB) begin
        n_trunc = !e_ol;
        n_last  = m_own;
        n_cnt   = 0;
        n_own   = ((m_own == 0) ? valid1 : valid0) ? 1 - m_own : -1;
      end
    end

    @(posedge clk);
    m_own = n_own; m_cnt = n_cnt; m_last = n_last; m_trunc = n_trunc;
    #1;
    if (acc0) void'(q0.pop_front());
    if (acc1) void'(q1.pop_front());
    if (!pres0 || acc0) pres0 = (q0.size() > 0) && (!gaps || $urandom_range(3) != 0);
    if (!pres1 || acc1) pres1 = (q1.size() > 0) && (!gaps || $urandom_range(3) != 0);
    drive();
  endtask

  task automatic drain(input int maxc);
    bit done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      step();
      done = (q0.size() == 0) && (q1.size() == 0) && (m_own < 0);
    end
    chk("drain_done", done, 1'b1);
    step();
  endtask

  initial begin
    int b0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_sel", sel, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_trunc", trunc, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ready0", ready0, 1'b0);
    chk("rst_ready1", ready1, 1'b0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();

    // Single 3-beat packet from source 0
    q0.push_back({1'b0, 8'h11});
    q0.push_back({1'b0, 8'h22});
    q0.push_back({1'b1, 8'h33});
    present_now();
    trunc_seen = 0;
    drain(20);
    chk("single_trunc", N'(trunc_seen), '0);

    // Tie from idle, twice: source 0 first, then source 1 with no bubble
    for (int t = 0; t < 2; t++) begin
      push(0, 2, 8'hA0);
      push(1, 2, 8'hB0);
      present_now();
      drain(20);
    end

    // Backpressure on source 1
    push(1, 3, 8'hC0);
    present_now();
    step();
    b0 = acc1_cnt;
    out_ready = 1'b1; step();
    out_ready = 1'b0; step();
    out_ready = 1'b0; step();
    out_ready = 1'b1; step();
    chk("bp_beats", N'(acc1_cnt - b0), N'(2));
    drain(20);

    // Truncation of a 6-beat packet
    trunc_seen = 0;
    push(0, 6, 8'h50);
    present_now();
    drain(30);
    chk("trunc_pulses", N'(trunc_seen), N'(1));

    // Last coincides with the limit beat
    trunc_seen = 0;
    push(0, MB, 8'h60);
    present_now();
    drain(30);
    chk("limit_last_trunc", N'(trunc_seen), '0);

    // Reset in the middle of a source 1 packet
    push(1, 5, 8'h70);
    present_now();
    b0 = acc1_cnt;
    for (int c = 0; c < 20 && (acc1_cnt - b0) < 2; c++) step();
    chk("pre_reset_beats", N'(acc1_cnt - b0), N'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", sel, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_ready1", ready1, 1'b0);
    q0.delete(); q1.delete();
    pres0 = 1'b0; pres1 = 1'b0;
    drive();
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    push(0, 2, 8'h80);
    present_now();
    drain(20);

    // Random traffic with gaps and random backpressure
    gaps = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (q0.size() < 2 && $urandom_range(7) == 0)
        push(0, int'($urandom_range(7, 1)), N'($urandom));
      if (q1.size() < 2 && $urandom_range(7) == 0)
        push(1, int'($urandom_range(7, 1)), N'($urandom));
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    out_ready = 1'b1;
    drain(400);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
